// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions used by the PC sequencer, the execute stage and the
// branch logic so that all of them agree on PC width and FSM encoding.
//   PC_W_DEF   : default program counter width (word-addressed)
//   CNT_W      : width of the refill bubble counter (REFILL_CYC is 0..7)
//   ST_*       : sequencer FSM state encoding
//   sat_inc16  : saturating 16-bit increment for the optional stats counters
package pc_sequencer_pkg;

  localparam int PC_W_DEF = 16;
  localparam int CNT_W    = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN    = 2'd0;
  localparam state_t ST_REFILL = 2'd1;
  localparam state_t ST_HALT   = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer for the 4-stage core.
// Redirects fetch on a taken branch, kills the younger in-flight instructions,
// inserts REFILL_CYC bubble cycles, and handles stall and halt/resume.
//
// Parameters:
//   PC_W        program counter width (word-addressed)
//   RESET_PC    PC value loaded on reset
//   REFILL_CYC  bubble cycles after a redirect (0..7), 0 = fetch target at once
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            synchronous reset, active-high
//   stall          hold PC and fetch
//   load_new_pc    taken branch/jump resolved this cycle
//   branch_target  redirect target, valid with load_new_pc
//   halt_req       level request to stop fetching
//   resume         one-cycle pulse, leave HALT
//   pc             current fetch address
//   fetch_valid    pc is a real fetch (0 = bubble)
//   flush          kill IF/ID-stage instructions this cycle (combinational)
//   halted         FSM is in HALT
//   taken_cnt      (PC_SEQ_STATS_EN only) accepted redirects, saturating
//   bubble_cnt     (PC_SEQ_STATS_EN only) non-HALT bubble cycles, saturating
//
// Build option: define PC_SEQ_STATS_EN to add the taken_cnt/bubble_cnt ports.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int unsigned     REFILL_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            load_new_pc,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic            halted
`ifdef PC_SEQ_STATS_EN
  ,
  output logic [15:0]     taken_cnt,
  output logic [15:0]     bubble_cnt
`endif
);

  localparam logic [CNT_W-1:0] REFILL_INIT = CNT_W'(REFILL_CYC);
  // With no refill bubbles a redirect fetches the target straight from RUN.
  localparam state_t REDIRECT_ST = (REFILL_CYC > 0) ? ST_REFILL : ST_RUN;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; a redirect always beats halt/resume and stall.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (load_new_pc) begin
          pc_nxt    = branch_target;
          state_nxt = REDIRECT_ST;
          cnt_nxt   = REFILL_INIT;
        end else if (halt_req) begin
          state_nxt = ST_HALT;
        end else if (!stall) begin
          pc_nxt = pc + PC_W'(1);
        end
      end
      ST_REFILL: begin
        // Latest redirect restarts the bubble count; stall and halt_req
        // have no effect until the pipeline is back in RUN.
        if (load_new_pc) begin
          pc_nxt  = branch_target;
          cnt_nxt = REFILL_INIT;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        if (load_new_pc) pc_nxt = branch_target;
        else if (resume) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs; while rst is held no fetch or redirect is reported.
  always_comb begin
    fetch_valid = (state == ST_RUN) && !rst;
    flush       = load_new_pc && (state != ST_HALT) && !rst;
    halted      = (state == ST_HALT);
  end

`ifdef PC_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (flush) taken_cnt <= sat_inc16(taken_cnt);
      if (!fetch_valid && (state != ST_HALT)) bubble_cnt <= sat_inc16(bubble_cnt);
    end
  end
`endif

endmodule
